// File: rtl/spi_frame_slave.sv
// Purpose : CRC-8 protected SPI mode-0 frame slave with a write register bank, status/readback reads and burst auto-increment.
// Latency : a write commits on the sclk edge that completes its CRC byte; miso is combinational from frame state.
// Backpressure: none; the SPI master paces every bit, and cs_n high aborts the frame at any point.
//
// Ports:
//   sclk         SPI clock, sole clock; mosi sampled on rising edge
//   rst_n        asynchronous active-low reset (bank, counters, frame state)
//   cs_n         active-low chip select; high asynchronously clears frame state only
//   mosi / miso  serial data in / out, MSB first; miso is 0 while cs_n is high
//   status_in    live status words, channel i at [i*DATA_W +: DATA_W]
//   reg_out      register bank contents, same packing
//   crc_err_cnt  saturating count of write CRC mismatches
//   addr_err_cnt saturating count of out-of-range accesses
module spi_frame_slave #(
    parameter int          NUM_CH     = 21,
    parameter int          DATA_BYTES = 1,
    parameter logic [7:0]  CRC_POLY   = 8'h07
) (
    input  logic                             sclk,
    input  logic                             rst_n,
    input  logic                             cs_n,
    input  logic                             mosi,
    output logic                             miso,
    input  logic [NUM_CH*DATA_BYTES*8-1:0]   status_in,
    output logic [NUM_CH*DATA_BYTES*8-1:0]   reg_out,
    output logic [7:0]                       crc_err_cnt,
    output logic [7:0]                       addr_err_cnt
);

    localparam int DATA_W = 8 * DATA_BYTES;
    localparam int BP_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_CRC,
        ST_DONE,
        ST_DROP
    } state_t;

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? CRC_POLY : 8'h00);
    endfunction

    // Frame state (cleared by rst_n or cs_n)
    state_t                state, state_nxt;
    logic [2:0]            bit_cnt;
    logic [1:0]            byte_idx;
    logic [7:0]            addr;
    logic [7:0]            shift_q;
    logic [7:0]            rx_crc;
    logic [7:0]            tx_crc;
    logic                  cmd_wr;
    logic                  cmd_burst;
    logic                  cmd_rd_reg;
    logic [DATA_W-1:0]     data_sr;

    // Persistent state (cleared by rst_n only)
    logic [NUM_CH*DATA_W-1:0] bank;

    // Decode helpers
    logic                  byte_last;
    logic                  data_last;
    logic [7:0]            rx_byte;
    logic                  addr_oob;
    logic                  crc_match;
    logic                  commit_evt;
    logic                  wr_ok;
    logic                  wr_addr_err;
    logic                  wr_crc_err;
    logic                  rd_addr_err;
    logic [DATA_W-1:0]     sel_word;
    logic [BP_W-1:0]       bit_pos;
    logic                  data_bit;

    assign byte_last = (bit_cnt == 3'd7);
    assign data_last = (byte_idx == 2'(DATA_BYTES - 1));
    assign rx_byte   = {shift_q[6:0], mosi};
    assign addr_oob  = (int'(addr) >= NUM_CH);
    assign crc_match = (rx_byte == rx_crc);

    assign commit_evt  = (state == ST_CRC) && byte_last && cmd_wr;
    assign wr_ok       = commit_evt && crc_match && !addr_oob;
    assign wr_addr_err = commit_evt && crc_match && addr_oob;
    assign wr_crc_err  = commit_evt && !crc_match;
    // Out-of-range reads count once per group, when its first data byte completes.
    assign rd_addr_err = (state == ST_DATA) && !cmd_wr && byte_last &&
                         (byte_idx == 2'd0) && addr_oob;

    // Word selected for a read; stays 0 for an out-of-range address.
    always_comb begin
        sel_word = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(addr) == i) begin
                sel_word = cmd_rd_reg ? bank[i*DATA_W +: DATA_W]
                                      : status_in[i*DATA_W +: DATA_W];
            end
        end
    end

    assign bit_pos  = BP_W'(DATA_W - 1 - 8 * int'(byte_idx) - int'(bit_cnt));
    assign data_bit = sel_word[bit_pos];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge sclk or negedge rst_n or posedge cs_n) begin
        if (!rst_n) begin
            state <= ST_CMD;
        end else if (cs_n) begin
            state <= ST_CMD;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_CMD:  if (byte_last) state_nxt = ST_ADDR;
            ST_ADDR: if (byte_last) state_nxt = ST_DATA;
            ST_DATA: if (byte_last && data_last) state_nxt = ST_CRC;
            ST_CRC: begin
                if (byte_last) begin
                    if (cmd_wr && !crc_match) state_nxt = ST_DROP;
                    else if (cmd_burst)       state_nxt = ST_DATA;
                    else                      state_nxt = ST_DONE;
                end
            end
            default: state_nxt = state;   // DONE / DROP hold until cs_n rises
        endcase
    end

    // ---------------- FSM: output logic ----------------
    always_comb begin
        miso = 1'b0;
        if (!cs_n && !cmd_wr) begin
            case (state)
                ST_DATA: miso = data_bit;
                ST_CRC:  miso = tx_crc[3'd7 - bit_cnt];
                default: miso = 1'b0;
            endcase
        end
    end

    // ---------------- Frame datapath ----------------
    always_ff @(posedge sclk or negedge rst_n or posedge cs_n) begin
        if (!rst_n) begin
            bit_cnt    <= 3'd0;
            byte_idx   <= 2'd0;
            addr       <= 8'd0;
            shift_q    <= 8'd0;
            rx_crc     <= 8'd0;
            tx_crc     <= 8'd0;
            cmd_wr     <= 1'b0;
            cmd_burst  <= 1'b0;
            cmd_rd_reg <= 1'b0;
            data_sr    <= '0;
        end else if (cs_n) begin
            bit_cnt    <= 3'd0;
            byte_idx   <= 2'd0;
            addr       <= 8'd0;
            shift_q    <= 8'd0;
            rx_crc     <= 8'd0;
            tx_crc     <= 8'd0;
            cmd_wr     <= 1'b0;
            cmd_burst  <= 1'b0;
            cmd_rd_reg <= 1'b0;
            data_sr    <= '0;
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
            shift_q <= rx_byte;
            case (state)
                ST_CMD: begin
                    rx_crc <= crc_step(rx_crc, mosi);
                    if (byte_last) begin
                        cmd_wr     <= rx_byte[7];
                        cmd_burst  <= rx_byte[6];
                        cmd_rd_reg <= rx_byte[0];
                    end
                end
                ST_ADDR: begin
                    rx_crc <= crc_step(rx_crc, mosi);
                    if (byte_last) begin
                        addr   <= rx_byte;
                        // Read reply CRC starts from the CRC of CMD and ADDR.
                        tx_crc <= crc_step(rx_crc, mosi);
                    end
                end
                ST_DATA: begin
                    if (cmd_wr) begin
                        rx_crc  <= crc_step(rx_crc, mosi);
                        data_sr <= {data_sr[DATA_W-2:0], mosi};
                    end else begin
                        tx_crc  <= crc_step(tx_crc, data_bit);
                    end
                    if (byte_last) begin
                        byte_idx <= data_last ? 2'd0 : byte_idx + 2'd1;
                    end
                end
                ST_CRC: begin
                    // rx_crc/tx_crc hold here so the CRC byte is excluded and
                    // the transmitted checksum stays frozen for the whole byte.
                    if (byte_last) begin
                        addr <= addr + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------- Register bank and error counters ----------------
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            bank         <= '0;
            crc_err_cnt  <= 8'd0;
            addr_err_cnt <= 8'd0;
        end else begin
            if (wr_ok) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (int'(addr) == i) begin
                        bank[i*DATA_W +: DATA_W] <= data_sr;
                    end
                end
            end
            if (wr_crc_err && (crc_err_cnt != 8'hFF)) begin
                crc_err_cnt <= crc_err_cnt + 8'd1;
            end
            if ((wr_addr_err || rd_addr_err) && (addr_err_cnt != 8'hFF)) begin
                addr_err_cnt <= addr_err_cnt + 8'd1;
            end
        end
    end

    assign reg_out = bank;

endmodule

// File: tb/tb_spi_frame_slave.sv
// Purpose : directed scoreboard bench for spi_frame_slave (NUM_CH=21, one data byte).
// Latency : expectations are queued before each frame and popped once the frame has ended.
// Backpressure: none; the bench is the SPI master and paces every bit itself.
module tb_spi_frame_slave;

    localparam int NUM_CH = 21;
    localparam int W      = NUM_CH * 8;

    logic          sclk;
    logic          rst_n;
    logic          cs_n;
    logic          mosi;
    logic          miso;
    logic [W-1:0]  status_in;
    logic [W-1:0]  reg_out;
    logic [7:0]    crc_err_cnt;
    logic [7:0]    addr_err_cnt;

    spi_frame_slave #(
        .NUM_CH     (NUM_CH),
        .DATA_BYTES (1),
        .CRC_POLY   (8'h07)
    ) dut (
        .sclk         (sclk),
        .rst_n        (rst_n),
        .cs_n         (cs_n),
        .mosi         (mosi),
        .miso         (miso),
        .status_in    (status_in),
        .reg_out      (reg_out),
        .crc_err_cnt  (crc_err_cnt),
        .addr_err_cnt (addr_err_cnt)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    int              vectors;
    int              miscompares;
    logic [255:0]    exp_q[$];
    logic [7:0]      tx_q[$];
    logic [7:0]      rx_q[$];

    logic [W-1:0]    m_regs;
    int              m_crc_err;
    int              m_addr_err;

    function automatic logic [7:0] crc_b(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            r = (r[7] ^ b[i]) ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs);
        logic [255:0] exp;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s: observed %h, no expected value queued", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    task automatic push_state();
        exp_q.push_back(256'(m_regs));
        exp_q.push_back(256'(m_crc_err));
        exp_q.push_back(256'(m_addr_err));
    endtask

    task automatic check_state(input string tag);
        check({tag, "_regs"},     256'(reg_out));
        check({tag, "_crc_err"},  256'(crc_err_cnt));
        check({tag, "_addr_err"}, 256'(addr_err_cnt));
    endtask

    task automatic bump_crc();
        if (m_crc_err < 255) m_crc_err++;
    endtask

    task automatic bump_addr();
        if (m_addr_err < 255) m_addr_err++;
    endtask

    // Shifts tx_q out (nbits < 0: everything), capturing miso per bit into rx_q.
    task automatic run_frame(input int nbits, input bit keep_cs);
        int         sent;
        logic [7:0] b;
        logic [7:0] r;
        rx_q.delete();
        sent = 0;
        @(negedge sclk);
        cs_n = 1'b0;
        foreach (tx_q[k]) begin
            b = tx_q[k];
            r = 8'h00;
            for (int i = 7; i >= 0; i--) begin
                if (nbits < 0 || sent < nbits) begin
                    if (sent != 0) @(negedge sclk);
                    mosi = b[i];
                    r[i] = miso;
                    sent++;
                end
            end
            rx_q.push_back(r);
        end
        if (!keep_cs) begin
            @(negedge sclk);
            cs_n = 1'b1;
            mosi = 1'b0;
            repeat (2) @(negedge sclk);
        end
    endtask

    logic [7:0] c1, c2;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        cs_n        = 1'b1;
        mosi        = 1'b0;
        status_in   = '0;
        status_in[3*8 +: 8] = 8'hA5;
        status_in[0*8 +: 8] = 8'h5A;
        m_regs      = '0;
        m_crc_err   = 0;
        m_addr_err  = 0;

        // Reset state
        repeat (3) @(negedge sclk);
        push_state();
        exp_q.push_back(256'(0));
        check_state("reset");
        check("reset_miso", 256'(miso));
        rst_n = 1'b1;
        repeat (2) @(negedge sclk);

        // Single write 80 05 01 4D
        m_regs[5*8 +: 8] = 8'h01;
        push_state();
        tx_q = '{8'h80, 8'h05, 8'h01, 8'h4D};
        run_frame(-1, 1'b0);
        check_state("wr_basic");

        // Bad CRC must not write; a following valid write commits
        c1 = crc_b(crc_b(crc_b(8'h00, 8'h80), 8'h05), 8'h07) ^ 8'h01;
        bump_crc();
        push_state();
        tx_q = '{8'h80, 8'h05, 8'h07, c1};
        run_frame(-1, 1'b0);
        check_state("wr_badcrc");

        c1 = crc_b(crc_b(crc_b(8'h00, 8'h80), 8'h05), 8'h33);
        m_regs[5*8 +: 8] = 8'h33;
        push_state();
        tx_q = '{8'h80, 8'h05, 8'h33, c1};
        run_frame(-1, 1'b0);
        check_state("wr_after_bad");

        // Status read of channel 3
        exp_q.push_back(256'(8'hA5));
        exp_q.push_back(256'(8'h4D));
        tx_q = '{8'h00, 8'h03, 8'h00, 8'h00};
        run_frame(-1, 1'b0);
        check("rd_status_data", 256'(rx_q[2]));
        check("rd_status_crc",  256'(rx_q[3]));

        // Register readback of channel 5
        exp_q.push_back(256'(8'h33));
        exp_q.push_back(256'(crc_b(crc_b(crc_b(8'h00, 8'h01), 8'h05), 8'h33)));
        tx_q = '{8'h01, 8'h05, 8'hFF, 8'hFF};
        run_frame(-1, 1'b0);
        check("rd_reg_data", 256'(rx_q[2]));
        check("rd_reg_crc",  256'(rx_q[3]));

        // Burst write at channel 20; second group lands out of range
        c1 = crc_b(crc_b(crc_b(8'h00, 8'hC0), 8'h14), 8'h01);
        c2 = crc_b(c1, 8'h01);
        m_regs[20*8 +: 8] = 8'h01;
        bump_addr();
        push_state();
        tx_q = '{8'hC0, 8'h14, 8'h01, c1, 8'h01, c2};
        run_frame(-1, 1'b0);
        check_state("burst_wr");

        // Burst readback of channels 19, 20 with running reply CRC
        c1 = crc_b(crc_b(crc_b(8'h00, 8'h41), 8'h13), 8'h00);
        c2 = crc_b(c1, 8'h01);
        exp_q.push_back(256'(8'h00));
        exp_q.push_back(256'(c1));
        exp_q.push_back(256'(8'h01));
        exp_q.push_back(256'(c2));
        tx_q = '{8'h41, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(-1, 1'b0);
        check("brd_d0", 256'(rx_q[2]));
        check("brd_c0", 256'(rx_q[3]));
        check("brd_d1", 256'(rx_q[4]));
        check("brd_c1", 256'(rx_q[5]));

        // Burst status read from 255 wrapping to channel 0
        c1 = crc_b(crc_b(crc_b(8'h00, 8'h40), 8'hFF), 8'h00);
        c2 = crc_b(c1, 8'h5A);
        exp_q.push_back(256'(8'h00));
        exp_q.push_back(256'(c1));
        exp_q.push_back(256'(8'h5A));
        exp_q.push_back(256'(c2));
        bump_addr();
        push_state();
        tx_q = '{8'h40, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(-1, 1'b0);
        check("wrap_d0", 256'(rx_q[2]));
        check("wrap_c0", 256'(rx_q[3]));
        check("wrap_d1", 256'(rx_q[4]));
        check("wrap_c1", 256'(rx_q[5]));
        check_state("wrap");

        // cs_n abort four bits into the data byte, then a full frame
        c1 = crc_b(crc_b(crc_b(8'h00, 8'h80), 8'h07), 8'h42);
        push_state();
        tx_q = '{8'h80, 8'h07, 8'h42, c1};
        run_frame(20, 1'b0);
        check_state("abort");
        m_regs[7*8 +: 8] = 8'h42;
        push_state();
        run_frame(-1, 1'b0);
        check_state("after_abort");

        // rst_n mid-burst
        c1 = crc_b(crc_b(crc_b(8'h00, 8'hC0), 8'h08), 8'h11);
        tx_q = '{8'hC0, 8'h08, 8'h11, c1, 8'h22};
        run_frame(36, 1'b1);
        @(negedge sclk);
        rst_n = 1'b0;
        #1;
        m_regs     = '0;
        m_crc_err  = 0;
        m_addr_err = 0;
        push_state();
        exp_q.push_back(256'(0));
        check_state("mid_rst");
        check("mid_rst_miso", 256'(miso));
        cs_n = 1'b1;
        mosi = 1'b0;
        #2;
        rst_n = 1'b1;
        repeat (2) @(negedge sclk);

        c1 = crc_b(crc_b(crc_b(8'h00, 8'h80), 8'h02), 8'h9C);
        m_regs[2*8 +: 8] = 8'h9C;
        push_state();
        tx_q = '{8'h80, 8'h02, 8'h9C, c1};
        run_frame(-1, 1'b0);
        check_state("post_rst");

        // CRC error counter saturation
        c1 = crc_b(crc_b(crc_b(8'h00, 8'h80), 8'h00), 8'h11) ^ 8'h80;
        tx_q = '{8'h80, 8'h00, 8'h11, c1};
        for (int n = 0; n < 254; n++) begin
            run_frame(-1, 1'b0);
            bump_crc();
        end
        exp_q.push_back(256'(m_crc_err));
        check("crc_254", 256'(crc_err_cnt));
        for (int n = 0; n < 2; n++) begin
            run_frame(-1, 1'b0);
            bump_crc();
        end
        push_state();
        check_state("crc_sat");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spi_frame_slave.md
Name: spi_frame_slave

Overview:
Parametrised successor to the SafetyBoard SPI slave. It decodes CRC-8 protected SPI frames that carry multi-byte data words and optional address auto-increment bursts. Writes go into an internal bank of NUM_CH registers. Reads return either live status inputs or register readback. It runs entirely in the SPI clock domain, uses SPI mode 0 and sends data MSB first, and it counts CRC and address errors for the safety monitor.

Parameters:
NUM_CH, 21, number of channels/registers (1..256)
DATA_BYTES, 1, data bytes per word (1..4); DATA_W = 8*DATA_BYTES
CRC_POLY, 8'h07, CRC-8 polynomial; init 8'h00, no reflection, no final XOR

Ports:
sclk  input  1  SPI clock, sole clock; MOSI sampled on rising edge
rst_n  input  1  asynchronous active-low reset
cs_n  input  1  chip select, active low; high asynchronously clears frame state
mosi  input  1  serial data in, MSB first
miso  output  1  serial data out, combinational from frame state, 0 when cs_n high
status_in  input  NUM_CH*DATA_W  live status words, channel i at [i*DATA_W +: DATA_W]
reg_out  output  NUM_CH*DATA_W  register bank contents, same packing
crc_err_cnt  output  8  saturating count of write CRC mismatches
addr_err_cnt  output  8  saturating count of out-of-range accesses

Behaviour:
- Reset: one clock (sclk). Reset is asynchronous and active-low on rst_n. While rst_n is low: reg_out=0, crc_err_cnt=0, addr_err_cnt=0, frame state=CMD, miso=0.
- Frame state (state, bit_cnt[2:0], byte_idx, addr, rx_crc, tx_crc, cmd) is also asynchronously cleared while cs_n=1. The bank and counters are not cleared by cs_n.
- Frame format: CMD, ADDR, DATA_BYTES data bytes, CRC. In burst mode, further {data, CRC} groups follow.
- CMD bits:
  - bit7 = 1 for write, 0 for read.
  - bit6 = 1 for burst.
  - bit0 (reads only) = 1 for reg_out readback, 0 for status_in.
  - bits5:1 are reserved and ignored.
- States: CMD -> ADDR -> DATA -> CRC -> (burst ? DATA : DONE). Also DROP. DONE and DROP ignore mosi, drive miso=0 and stay until cs_n rises.
- Each state advances on the rising edge where bit_cnt=7, i.e. the byte is complete. DATA advances after byte DATA_BYTES-1.
- CRC engine: serial, one bit per edge: crc = {crc[6:0],1'b0} ^ ((crc[7]^bit) ? CRC_POLY : 0).
- rx_crc: runs over every mosi bit of CMD, ADDR and DATA bytes. CRC bytes are excluded. It is not reset between burst groups.
- Write commit: on the edge completing a CRC byte, compare the received byte with rx_crc.
  - On match with addr < NUM_CH: the bank word at addr gets the assembled data (first byte is the MSB). reg_out updates on that edge.
  - On match with addr >= NUM_CH: no write; addr_err_cnt +1.
  - On mismatch: no write; crc_err_cnt +1; go to DROP (rest of the frame is ignored).
- Read: mosi is ignored after ADDR, and no rx CRC check is done.
  - During DATA, miso = bit (DATA_W-1 - 8*byte_idx - bit_cnt) of the selected word at addr. This is combinational, so it is valid before the next rising edge.
  - The selected word is 0 if addr >= NUM_CH. addr_err_cnt +1 once per out-of-range group, counted at the first DATA byte.
  - tx_crc is seeded at the end of ADDR with the CRC of CMD and ADDR. It then runs over each transmitted data bit.
  - During the CRC byte, miso = tx_crc[7-bit_cnt], with tx_crc frozen at its value when the CRC byte starts.
- Burst: after each CRC byte, addr increments by 1. addr is 8 bits and wraps 255 -> 0.
- Counters saturate at 8'hFF. Simultaneous increments of both counters on one edge are allowed.
- cs_n rising mid-frame: no partial write, frame state is cleared, and the next frame restarts at CMD. Writes already committed by earlier burst groups remain.
- Writes are only visible at reg_out. Readback of the same address in a later frame returns the new value.

Test Plan:
- Write 80 05 01 4D (NUM_CH=21, DATA_BYTES=1) -> reg_out channel 5 = 8'h01; all others 0; both counters 0.
- Write 80 05 01 4C -> no write; crc_err_cnt=1; a following valid frame 80 05 01 4D still commits.
- Read with status_in channel 3 = 8'hA5: send 00 03 xx xx -> miso byte 2 = A5, byte 3 = 4D.
- Burst write C0 14 {01, crc} {01, crc} using the running CRC -> channel 20 = 01; second group dropped; addr_err_cnt=1.
- cs_n high after 4 bits of the data byte, then a full valid frame -> first frame writes nothing; second commits; no counter change.
- rst_n pulsed low mid-burst -> reg_out and counters = 0 immediately; the next frame decodes normally; counters saturate at FF after 256 bad-CRC frames.
